// File: rtl/dpm_arb_pkg.sv
// rtl/dpm_arb_pkg.sv - shared defaults, id width helper and port tag type for dpm_arbiter
package dpm_arb_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 16;
   localparam int MAX_REQ    = 8;
   localparam int ID_W       = $clog2(MAX_REQ);

   typedef struct packed {
      logic            valid;
      logic            is_read;
      logic [ID_W-1:0] id;
   } port_tag_t;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dpm_rr_pick.sv
// rtl/dpm_rr_pick.sv - first set request at or after a pointer, wrapping modulo N
module dpm_rr_pick
   import dpm_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = id_width(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic          found_o,
   output logic [IW-1:0] idx_o
);

   logic [2*N-1:0] rot;

   always_comb begin
      int sum;
      found_o = 1'b0;
      idx_o   = '0;
      sum     = 0;
      // Doubling the vector turns the wrap into a plain shift.
      rot     = {req_i, req_i} >> ptr_i;
      for (int k = 0; k < N; k++) begin
         if (!found_o && rot[k]) begin
            found_o = 1'b1;
            sum     = int'(ptr_i) + k;
            if (sum >= N) sum = sum - N;
            idx_o   = IW'(sum);
         end
      end
   end

endmodule

// File: rtl/dpm_arbiter.sv
// rtl/dpm_arbiter.sv - round-robin two-port scheduler for DualPortMem; DPM_ARB_STATS_EN adds grant/conflict counters
module dpm_arbiter
   import dpm_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int addrW = DEF_ADDR_W,
   parameter int dataW = DEF_DATA_W,
   parameter int CNTW  = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [N_REQ-1:0]       req_i,
   input  logic [N_REQ-1:0]       we_i,
   input  logic [N_REQ*addrW-1:0] addr_i,
   input  logic [N_REQ*dataW-1:0] wdata_i,
   output logic [N_REQ-1:0]       gnt_o,
   output logic [N_REQ-1:0]       rvalid_o,
   output logic [N_REQ*dataW-1:0] rdata_o,
   output logic [dataW-1:0]       dInA_o,
   output logic [addrW-1:0]       addrA_o,
   output logic                   wEnA_o,
   output logic                   EnA_o,
   input  logic [dataW-1:0]       dOutA_i,
   output logic [dataW-1:0]       dInB_o,
   output logic [addrW-1:0]       addrB_o,
   output logic                   wEnB_o,
   output logic                   EnB_o,
   input  logic [dataW-1:0]       dOutB_i,
   input  logic                   collision_i,
   output logic [CNTW-1:0]        conflict_cnt_o,
   output logic [CNTW-1:0]        grant_cnt_o
);

   localparam int IW = id_width(N_REQ);

   logic [addrW-1:0] addr_arr  [N_REQ];
   logic [dataW-1:0] wdata_arr [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign addr_arr[g]  = addr_i[g*addrW +: addrW];
      assign wdata_arr[g] = wdata_i[g*dataW +: dataW];
   end

   function automatic logic [IW-1:0] nxt(input logic [IW-1:0] x);
      return (int'(x) == N_REQ - 1) ? '0 : x + 1'b1;
   endfunction

   logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]    cand_a, cand_b;
   logic             found_a, found_b, conflict, grant_b;
   logic [N_REQ-1:0] req_b;

   logic [dataW-1:0] din_a_q, din_b_q;
   logic [addrW-1:0] addr_a_q, addr_b_q;
   logic             wen_a_q, wen_b_q, en_a_q, en_b_q;
   port_tag_t        tag_a_d, tag_b_d, tag1_a_q, tag1_b_q, tag2_a_q, tag2_b_q;

   logic             collision_unused;
   assign collision_unused = collision_i;

   dpm_rr_pick #(.N(N_REQ), .IW(IW)) u_pick_a (
      .req_i   (req_i),
      .ptr_i   (rr_ptr_q),
      .found_o (found_a),
      .idx_o   (cand_a)
   );

   // Bits between rr_ptr and candA are already zero, so masking candA
   // limits the second search to the range that ends before rr_ptr.
   always_comb begin
      req_b         = req_i;
      req_b[cand_a] = 1'b0;
   end

   dpm_rr_pick #(.N(N_REQ), .IW(IW)) u_pick_b (
      .req_i   (req_b),
      .ptr_i   (nxt(cand_a)),
      .found_o (found_b),
      .idx_o   (cand_b)
   );

   assign conflict = found_b && (addr_arr[cand_a] == addr_arr[cand_b])
                     && (we_i[cand_a] || we_i[cand_b]);
   assign grant_b  = found_b && !conflict;

   always_comb begin
      gnt_o = '0;
      if (!rst_i) begin
         if (found_a) gnt_o[cand_a] = 1'b1;
         if (grant_b) gnt_o[cand_b] = 1'b1;
      end
      rr_ptr_d = grant_b ? nxt(cand_b) : (found_a ? nxt(cand_a) : rr_ptr_q);

      tag_a_d         = '0;
      tag_a_d.valid   = found_a;
      tag_a_d.is_read = ~we_i[cand_a];
      tag_a_d.id      = ID_W'(cand_a);
      tag_b_d         = '0;
      tag_b_d.valid   = grant_b;
      tag_b_d.is_read = ~we_i[cand_b];
      tag_b_d.id      = ID_W'(cand_b);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q <= '0;
         en_a_q   <= 1'b0;
         wen_a_q  <= 1'b0;
         addr_a_q <= '0;
         din_a_q  <= '0;
         en_b_q   <= 1'b0;
         wen_b_q  <= 1'b0;
         addr_b_q <= '0;
         din_b_q  <= '0;
         tag1_a_q <= '0;
         tag1_b_q <= '0;
         tag2_a_q <= '0;
         tag2_b_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         en_a_q   <= found_a;
         wen_a_q  <= found_a && we_i[cand_a];
         addr_a_q <= found_a ? addr_arr[cand_a] : '0;
         din_a_q  <= found_a ? wdata_arr[cand_a] : '0;
         en_b_q   <= grant_b;
         wen_b_q  <= grant_b && we_i[cand_b];
         addr_b_q <= grant_b ? addr_arr[cand_b] : '0;
         din_b_q  <= grant_b ? wdata_arr[cand_b] : '0;
         tag1_a_q <= tag_a_d;
         tag1_b_q <= tag_b_d;
         tag2_a_q <= tag1_a_q;
         tag2_b_q <= tag1_b_q;
      end
   end

   assign EnA_o   = en_a_q;
   assign wEnA_o  = wen_a_q;
   assign addrA_o = addr_a_q;
   assign dInA_o  = din_a_q;
   assign EnB_o   = en_b_q;
   assign wEnB_o  = wen_b_q;
   assign addrB_o = addr_b_q;
   assign dInB_o  = din_b_q;

   // Tags reaching stage 2 line up with the memory's registered read data.
   always_comb begin
      rvalid_o = '0;
      rdata_o  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (tag2_a_q.valid && tag2_a_q.is_read && tag2_a_q.id == ID_W'(i)) begin
            rvalid_o[i]                = 1'b1;
            rdata_o[i*dataW +: dataW]  = dOutA_i;
         end
         if (tag2_b_q.valid && tag2_b_q.is_read && tag2_b_q.id == ID_W'(i)) begin
            rvalid_o[i]                = 1'b1;
            rdata_o[i*dataW +: dataW]  = dOutB_i;
         end
      end
   end

`ifdef DPM_ARB_STATS_EN
   logic [CNTW-1:0] grant_cnt_q, conflict_cnt_q;
   logic [CNTW:0]   grant_sum;

   assign grant_sum = {1'b0, grant_cnt_q} + (CNTW+1)'(found_a) + (CNTW+1)'(grant_b);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         grant_cnt_q    <= '0;
         conflict_cnt_q <= '0;
      end else begin
         grant_cnt_q <= grant_sum[CNTW] ? '1 : grant_sum[CNTW-1:0];
         if (conflict && conflict_cnt_q != '1) conflict_cnt_q <= conflict_cnt_q + 1'b1;
      end
   end

   assign grant_cnt_o    = grant_cnt_q;
   assign conflict_cnt_o = conflict_cnt_q;
`else
   assign grant_cnt_o    = '0;
   assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dpm_arbiter.sv
// tb/tb_dpm_arbiter.sv - self-checking bench for dpm_arbiter with a behavioural dual-port memory
module tb_dpm_arbiter;

   localparam int N  = 4;
   localparam int AW = 8;
   localparam int DW = 16;
   localparam int CW = 16;
   localparam int NV = 22;
   localparam int NRAND = 3000;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req, we, gnt, rvalid;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] wdata, rdata;
   logic [DW-1:0]   dInA, dInB, dOutA, dOutB;
   logic [AW-1:0]   addrA, addrB;
   logic            wEnA, EnA, wEnB, EnB, collision;
   logic [CW-1:0]   conflict_cnt, grant_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   logic [DW-1:0] mem     [1<<AW];
   logic [DW-1:0] ref_mem [1<<AW];

   always #5 clk = ~clk;

   dpm_arbiter #(.N_REQ(N), .addrW(AW), .dataW(DW), .CNTW(CW)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .req_i          (req),
      .we_i           (we),
      .addr_i         (addr),
      .wdata_i        (wdata),
      .gnt_o          (gnt),
      .rvalid_o       (rvalid),
      .rdata_o        (rdata),
      .dInA_o         (dInA),
      .addrA_o        (addrA),
      .wEnA_o         (wEnA),
      .EnA_o          (EnA),
      .dOutA_i        (dOutA),
      .dInB_o         (dInB),
      .addrB_o        (addrB),
      .wEnB_o         (wEnB),
      .EnB_o          (EnB),
      .dOutB_i        (dOutB),
      .collision_i    (collision),
      .conflict_cnt_o (conflict_cnt),
      .grant_cnt_o    (grant_cnt)
   );

   function automatic logic [DW-1:0] init_val(input int i);
      case (i)
         'h10:    return 16'hAAAA;
         'h20:    return 16'hBBBB;
         'h30:    return 16'h1234;
         default: return DW'(i * 257) ^ 16'h5A5A;
      endcase
   endfunction

   // Memory with registered read data; contents restored on rst.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < (1<<AW); i++) mem[i] <= init_val(i);
      end else begin
         if (EnA) begin
            if (wEnA) mem[addrA] <= dInA;
            dOutA <= mem[addrA];
         end
         if (EnB) begin
            if (wEnB) mem[addrB] <= dInB;
            dOutB <= mem[addrB];
         end
      end
   end

   assign collision = EnA && EnB && (addrA == addrB) && (wEnA || wEnB);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [N-1:0]    req;
      logic [N-1:0]    we;
      logic [N*AW-1:0] addr;
      logic [N*DW-1:0] wdata;
      logic [N-1:0]    exp_gnt;
      logic [N-1:0]    exp_rv;
      logic [N*DW-1:0] exp_rd;
   } vec_t;

   vec_t tbl [NV];

   function automatic vec_t mk(input logic [3:0] r, input logic [3:0] w, input logic [31:0] a,
                               input logic [63:0] d, input logic [3:0] g, input logic [3:0] rv,
                               input logic [63:0] rd);
      vec_t v;
      v.req = r; v.we = w; v.addr = a; v.wdata = d;
      v.exp_gnt = g; v.exp_rv = rv; v.exp_rd = rd;
      return v;
   endfunction

   bit            pend   [N];
   int            waitc  [N];
   bit            ev     [4][N];
   logic [DW-1:0] ed     [4][N];
   int            rr, ga, gb, slot, j;
   logic [N-1:0]  expg;

   task automatic service(input int g, input int cyc);
      logic [AW-1:0] a;
      a = addr[g*AW +: AW];
      chk($sformatf("wait r%0d", g), waitc[g] < N, 1);
      if (we[g]) ref_mem[a] = wdata[g*DW +: DW];
      else begin
         ev[(cyc+2)%4][g] = 1'b1;
         ed[(cyc+2)%4][g] = ref_mem[a];
      end
      pend[g] = 1'b0;
   endtask

   initial begin
      tbl[0]  = mk(4'b0001, 4'b0001, 32'h0000_0001, 64'h2, 4'b0001, 4'b0000, 64'h0);
      tbl[1]  = mk(4'b0001, 4'b0000, 32'h0000_0001, 64'h0, 4'b0001, 4'b0000, 64'h0);
      tbl[2]  = mk(4'b0000, 4'b0000, 32'h0,          64'h0, 4'b0000, 4'b0000, 64'h0);
      tbl[3]  = mk(4'b0000, 4'b0000, 32'h0,          64'h0, 4'b0000, 4'b0001, 64'h2);
      tbl[4]  = mk(4'b0011, 4'b0000, 32'h0000_2010, 64'h0, 4'b0011, 4'b0000, 64'h0);
      tbl[5]  = mk(4'b0000, 4'b0000, 32'h0,          64'h0, 4'b0000, 4'b0000, 64'h0);
      tbl[6]  = mk(4'b0000, 4'b0000, 32'h0,          64'h0, 4'b0000, 4'b0011, 64'h0000_0000_BBBB_AAAA);
      tbl[7]  = mk(4'b1000, 4'b0000, 32'h3000_0000, 64'h0, 4'b1000, 4'b0000, 64'h0);
      tbl[8]  = mk(4'b0011, 4'b0011, 32'h0000_0505, 64'h0000_0000_0008_0007, 4'b0001, 4'b0000, 64'h0);
      tbl[9]  = mk(4'b0010, 4'b0010, 32'h0000_0500, 64'h0000_0000_0008_0000, 4'b0010, 4'b1000, 64'h1234_0000_0000_0000);
      tbl[10] = mk(4'b0001, 4'b0000, 32'h0000_0005, 64'h0, 4'b0001, 4'b0000, 64'h0);
      tbl[11] = mk(4'b0000, 4'b0000, 32'h0,          64'h0, 4'b0000, 4'b0000, 64'h0);
      tbl[12] = mk(4'b0000, 4'b0000, 32'h0,          64'h0, 4'b0000, 4'b0001, 64'h8);
      tbl[13] = mk(4'b1000, 4'b0000, 32'h3000_0000, 64'h0, 4'b1000, 4'b0000, 64'h0);
      tbl[14] = mk(4'b1111, 4'b0000, 32'h0130_2010, 64'h0, 4'b0011, 4'b0000, 64'h0);
      tbl[15] = mk(4'b1111, 4'b0000, 32'h0130_2010, 64'h0, 4'b1100, 4'b1000, 64'h1234_0000_0000_0000);
      tbl[16] = mk(4'b1111, 4'b0000, 32'h0130_2010, 64'h0, 4'b0011, 4'b0011, 64'h0000_0000_BBBB_AAAA);
      tbl[17] = mk(4'b0000, 4'b0000, 32'h0,          64'h0, 4'b0000, 4'b1100, 64'h0002_1234_0000_0000);
      tbl[18] = mk(4'b0000, 4'b0000, 32'h0,          64'h0, 4'b0000, 4'b0011, 64'h0000_0000_BBBB_AAAA);
      tbl[19] = mk(4'b1100, 4'b0000, 32'h3030_0000, 64'h0, 4'b1100, 4'b0000, 64'h0);
      tbl[20] = mk(4'b0000, 4'b0000, 32'h0,          64'h0, 4'b0000, 4'b0000, 64'h0);
      tbl[21] = mk(4'b0000, 4'b0000, 32'h0,          64'h0, 4'b0000, 4'b1100, 64'h1234_1234_0000_0000);

      rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
      repeat (3) @(negedge clk);
      chk("reset gnt", gnt, 0);
      chk("reset rvalid", rvalid, 0);
      chk("reset rdata", rdata, 0);
      chk("reset en", {EnA, EnB, wEnA, wEnB}, 0);
      chk("reset port addr/data", {addrA, addrB, dInA, dInB}, 0);
      chk("reset counters", {grant_cnt, conflict_cnt}, 0);
      rst = 1'b0;

      for (int r = 0; r < NV; r++) begin
         @(negedge clk);
         chk($sformatf("tbl%0d collision", r), collision, 0);
         req = tbl[r].req; we = tbl[r].we; addr = tbl[r].addr; wdata = tbl[r].wdata;
         #1;
         chk($sformatf("tbl%0d gnt", r), gnt, tbl[r].exp_gnt);
         chk($sformatf("tbl%0d rvalid", r), rvalid, tbl[r].exp_rv);
         for (int i = 0; i < N; i++)
            if (tbl[r].exp_rv[i])
               chk($sformatf("tbl%0d rdata%0d", r, i), rdata[i*DW +: DW], tbl[r].exp_rd[i*DW +: DW]);
      end
      @(negedge clk);
`ifdef DPM_ARB_STATS_EN
      chk("grant_cnt", grant_cnt, 17);
      chk("conflict_cnt", conflict_cnt, 1);
`else
      chk("grant_cnt tied", grant_cnt, 0);
      chk("conflict_cnt tied", conflict_cnt, 0);
`endif

      // Reset one cycle after a read grant: the response must vanish.
      req = 4'b0001; we = '0; addr = 32'h0000_0010;
      #1;
      chk("rst seq gnt", gnt, 4'b0001);
      @(negedge clk);
      rst = 1'b1; req = '0;
      @(negedge clk);
      rst = 1'b0;
      chk("post-rst en", {EnA, EnB, wEnA, wEnB}, 0);
      chk("post-rst port addr/data", {addrA, addrB, dInA, dInB}, 0);
      chk("post-rst rdata", rdata, 0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("post-rst rvalid c%0d", k), rvalid, 0);
         @(negedge clk);
      end
      req = 4'b0111; addr = 32'h0030_2010;
      #1;
      chk("post-rst rr_ptr restart", gnt, 4'b0011);
      @(negedge clk);
      req = '0;
      repeat (4) @(negedge clk);

      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < (1<<AW); i++) ref_mem[i] = init_val(i);
      rr = 0;
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b0; waitc[i] = 0;
         for (int s = 0; s < 4; s++) ev[s][i] = 1'b0;
      end

      for (int c = 0; c < NRAND + 4; c++) begin
         @(negedge clk);
         chk("rand collision", collision, 0);
         slot = c % 4;
         for (int i = 0; i < N; i++) begin
            chk($sformatf("rand c%0d rvalid%0d", c, i), rvalid[i], ev[slot][i]);
            if (ev[slot][i]) chk($sformatf("rand c%0d rdata%0d", c, i), rdata[i*DW +: DW], ed[slot][i]);
            ev[slot][i] = 1'b0;
         end
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && c < NRAND && $urandom_range(0, 99) < 55) begin
               pend[i]  = 1'b1;
               waitc[i] = 0;
               we[i]    = ($urandom_range(0, 99) < 35);
               addr[i*AW +: AW]  = AW'($urandom_range(0, 7));
               wdata[i*DW +: DW] = DW'($urandom);
            end
            req[i] = pend[i];
         end
         #1;
         ga = -1; gb = -1;
         for (int k = 0; k < N; k++) begin
            j = (rr + k) % N;
            if (pend[j]) begin
               if (ga < 0) ga = j;
               else if (gb < 0) gb = j;
            end
         end
         if (gb >= 0 && addr[ga*AW +: AW] == addr[gb*AW +: AW] && (we[ga] || we[gb])) gb = -1;
         expg = '0;
         if (ga >= 0) expg[ga] = 1'b1;
         if (gb >= 0) expg[gb] = 1'b1;
         chk($sformatf("rand c%0d gnt", c), gnt, expg);
         if (ga >= 0) service(ga, c);
         if (gb >= 0) service(gb, c);
         for (int i = 0; i < N; i++) if (pend[i]) waitc[i]++;
         if (gb >= 0) rr = (gb + 1) % N;
         else if (ga >= 0) rr = (ga + 1) % N;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
